// File: rtl/vx_mem_perf_monitor.sv
// vx_mem_perf_monitor: memory-traffic performance monitor for one core.
// Counts read/write requests and responses over NUM_REQS channels and tracks
// in-flight reads. Each cycle it adds the current pending count to latency_sum
// and tracks the peak pending count. It latches a snapshot of loads and
// latency_sum when busy falls.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   req_valid/ready/rw  per-channel request handshake and type (1 = write)
//   rsp_valid/ready     per-channel response handshake
//   clear               zero all counters except pending and snapshot
//   busy                core busy; a falling edge triggers a snapshot
//   loads/stores/rsps   event counters (wrap)
//   pending             reads in flight; max_pending is its peak
//   latency_sum         saturating sum of pending, one add per cycle
//   err_underflow/overflow  sticky pending clamp flags
//   snap_valid/snap_loads/snap_latency  snapshot pulse and held values
module vx_mem_perf_monitor #(
  parameter int unsigned NUM_REQS  = 4,
  parameter int unsigned CTR_BITS  = 44,
  parameter int unsigned PEND_BITS = 16,
  parameter int unsigned REQ_DELAY = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQS-1:0]  req_valid,
  input  logic [NUM_REQS-1:0]  req_ready,
  input  logic [NUM_REQS-1:0]  req_rw,
  input  logic [NUM_REQS-1:0]  rsp_valid,
  input  logic [NUM_REQS-1:0]  rsp_ready,
  input  logic                 clear,
  input  logic                 busy,
  output logic [CTR_BITS-1:0]  loads,
  output logic [CTR_BITS-1:0]  stores,
  output logic [CTR_BITS-1:0]  rsps,
  output logic [PEND_BITS-1:0] pending,
  output logic [PEND_BITS-1:0] max_pending,
  output logic [CTR_BITS-1:0]  latency_sum,
  output logic                 err_underflow,
  output logic                 err_overflow,
  output logic                 snap_valid,
  output logic [CTR_BITS-1:0]  snap_loads,
  output logic [CTR_BITS-1:0]  snap_latency
);

  localparam int unsigned CntW   = $clog2(NUM_REQS + 1);
  localparam int unsigned DeltaW = CntW + 1;
  localparam int unsigned SumW   = PEND_BITS + 2;

  logic [NUM_REQS-1:0] rd_fire, wr_fire, rsp_fire;
  logic [NUM_REQS-1:0] rd_cnt_vec, wr_cnt_vec;
  logic                req_clr;  // clear seen in the cycle the counted requests fired

  assign rd_fire  = req_valid & req_ready & ~req_rw;
  assign wr_fire  = req_valid & req_ready & req_rw;
  assign rsp_fire = rsp_valid & rsp_ready;

  if (REQ_DELAY != 0) begin : g_delay
    always_ff @(posedge clk) begin
      if (reset) begin
        rd_cnt_vec <= '0;
        wr_cnt_vec <= '0;
        req_clr    <= 1'b0;
      end else begin
        rd_cnt_vec <= rd_fire;
        wr_cnt_vec <= wr_fire;
        req_clr    <= clear;
      end
    end
  end else begin : g_no_delay
    assign rd_cnt_vec = rd_fire;
    assign wr_cnt_vec = wr_fire;
    assign req_clr    = clear;
  end

  logic [CntW-1:0] n_rd, n_wr, n_rsp;

  always_comb begin
    n_rd  = '0;
    n_wr  = '0;
    n_rsp = '0;
    for (int i = 0; i < int'(NUM_REQS); i++) begin
      n_rd  = n_rd  + CntW'(rd_cnt_vec[i]);
      n_wr  = n_wr  + CntW'(wr_cnt_vec[i]);
      n_rsp = n_rsp + CntW'(rsp_fire[i]);
    end
  end

  logic [CTR_BITS-1:0]  loads_q, stores_q, rsps_q, lat_q, snap_loads_q, snap_lat_q;
  logic [CTR_BITS-1:0]  loads_d, stores_d, rsps_d, lat_d;
  logic [PEND_BITS-1:0] pend_q, pend_d, maxp_q, maxp_d;
  logic                 uf_q, uf_d, of_q, of_d, busy_q, snap_valid_q, fall;
  logic [DeltaW-1:0]    delta;
  logic [SumW-1:0]      pend_sum;
  logic [CTR_BITS:0]    lat_sum;
  logic                 neg, over;

  always_comb begin
    // Two's-complement add: the top bit of pend_sum is the sign.
    delta    = {1'b0, n_rd} - {1'b0, n_rsp};
    pend_sum = {2'b00, pend_q} + {{(SumW - DeltaW){delta[DeltaW-1]}}, delta};
    neg      = pend_sum[SumW-1];
    over     = ~neg & pend_sum[PEND_BITS];
    if (neg)       pend_d = '0;
    else if (over) pend_d = '1;
    else           pend_d = pend_sum[PEND_BITS-1:0];

    lat_sum = {1'b0, lat_q} + (CTR_BITS + 1)'(pend_q);

    loads_d  = loads_q;
    stores_d = stores_q;
    if (clear) begin
      loads_d  = '0;
      stores_d = '0;
      rsps_d   = '0;
      lat_d    = '0;
      maxp_d   = '0;
      uf_d     = 1'b0;
      of_d     = 1'b0;
    end else begin
      if (!req_clr) begin
        loads_d  = loads_q + CTR_BITS'(n_rd);
        stores_d = stores_q + CTR_BITS'(n_wr);
      end
      rsps_d = rsps_q + CTR_BITS'(n_rsp);
      lat_d  = lat_sum[CTR_BITS] ? '1 : lat_sum[CTR_BITS-1:0];
      maxp_d = (pend_d > maxp_q) ? pend_d : maxp_q;
      uf_d   = uf_q | neg;
      of_d   = of_q | over;
    end

    fall = busy_q & ~busy;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      loads_q      <= '0;
      stores_q     <= '0;
      rsps_q       <= '0;
      lat_q        <= '0;
      pend_q       <= '0;
      maxp_q       <= '0;
      uf_q         <= 1'b0;
      of_q         <= 1'b0;
      busy_q       <= 1'b0;
      snap_valid_q <= 1'b0;
      snap_loads_q <= '0;
      snap_lat_q   <= '0;
    end else begin
      loads_q      <= loads_d;
      stores_q     <= stores_d;
      rsps_q       <= rsps_d;
      lat_q        <= lat_d;
      pend_q       <= pend_d;
      maxp_q       <= maxp_d;
      uf_q         <= uf_d;
      of_q         <= of_d;
      busy_q       <= busy;
      snap_valid_q <= fall;
      if (fall) begin
        snap_loads_q <= loads_d;
        snap_lat_q   <= lat_d;
      end
    end
  end

  assign loads         = loads_q;
  assign stores        = stores_q;
  assign rsps          = rsps_q;
  assign pending       = pend_q;
  assign max_pending   = maxp_q;
  assign latency_sum   = lat_q;
  assign err_underflow = uf_q;
  assign err_overflow  = of_q;
  assign snap_valid    = snap_valid_q;
  assign snap_loads    = snap_loads_q;
  assign snap_latency  = snap_lat_q;

endmodule

// File: tb/tb_vx_mem_perf_monitor.sv
// Bench for vx_mem_perf_monitor (defaults: 4 channels, REQ_DELAY=1).
module tb_vx_mem_perf_monitor;

  localparam int CB = 44;
  localparam int PB = 16;
  localparam longint CtrMax  = (64'sd1 <<< CB) - 1;
  localparam int     PendMax = (1 << PB) - 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [3:0] req_valid = '0, req_ready = '0, req_rw = '0, rsp_valid = '0, rsp_ready = '0;
  logic clear = 1'b0, busy = 1'b0;
  logic [CB-1:0] loads, stores, rsps, latency_sum, snap_loads, snap_latency;
  logic [PB-1:0] pending, max_pending;
  logic err_underflow, err_overflow, snap_valid;

  vx_mem_perf_monitor dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_rw(req_rw), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .clear(clear),
    .busy(busy), .loads(loads), .stores(stores), .rsps(rsps), .pending(pending),
    .max_pending(max_pending), .latency_sum(latency_sum), .err_underflow(err_underflow),
    .err_overflow(err_overflow), .snap_valid(snap_valid), .snap_loads(snap_loads),
    .snap_latency(snap_latency)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: plain integer bookkeeping of the monitor's rules.
  longint m_loads, m_stores, m_rsps, m_lat, m_snap_loads, m_snap_lat;
  int     m_pend, m_maxp, m_prev_rd, m_prev_wr;
  bit     m_uf, m_of, m_prev_clr, m_busy_q, m_snap_v;

  function automatic int pop(input logic [3:0] v);
    int c = 0;
    for (int i = 0; i < 4; i++) c += int'(v[i]);
    return c;
  endfunction

  task automatic model_step();
    int cur_rd, cur_wr, n_rsp, p;
    cur_rd = pop(req_valid & req_ready & ~req_rw);
    cur_wr = pop(req_valid & req_ready & req_rw);
    n_rsp  = pop(rsp_valid & rsp_ready);
    if (reset) begin
      m_loads = 0; m_stores = 0; m_rsps = 0; m_lat = 0; m_snap_loads = 0; m_snap_lat = 0;
      m_pend = 0; m_maxp = 0; m_prev_rd = 0; m_prev_wr = 0;
      m_uf = 0; m_of = 0; m_prev_clr = 0; m_busy_q = 0; m_snap_v = 0;
      return;
    end
    // Reads are seen by the tracker one cycle after they fire.
    p = m_pend + m_prev_rd - n_rsp;
    if (clear) m_lat = 0;
    else m_lat = (m_lat + m_pend > CtrMax) ? CtrMax : m_lat + m_pend;
    if (clear) begin
      m_loads = 0; m_stores = 0; m_rsps = 0; m_maxp = 0; m_uf = 0; m_of = 0;
    end else begin
      if (p < 0) m_uf = 1;
      if (p > PendMax) m_of = 1;
      if (!m_prev_clr) begin
        m_loads  += m_prev_rd;
        m_stores += m_prev_wr;
      end
      m_rsps += n_rsp;
    end
    if (p < 0) p = 0;
    if (p > PendMax) p = PendMax;
    m_pend = p;
    if (!clear && p > m_maxp) m_maxp = p;
    m_snap_v = m_busy_q && !busy;
    if (m_snap_v) begin
      m_snap_loads = m_loads;
      m_snap_lat   = m_lat;
    end
    m_busy_q = busy; m_prev_rd = cur_rd; m_prev_wr = cur_wr; m_prev_clr = clear;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid = '0; req_ready = '0; req_rw = '0; rsp_valid = '0; rsp_ready = '0; clear = 0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1; tick(); tick(); reset = 0;
  endtask

  task automatic test_reset();
    busy = 0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      tick();
      n_vec++;
      if ({loads, stores, rsps, pending, max_pending, latency_sum, err_underflow,
           err_overflow, snap_valid, snap_loads, snap_latency} !== '0) begin
        n_err++;
        $display("FAIL reset_idle cyc %0d: loads=%0d stores=%0d rsps=%0d pend=%0d lat=%0d snap_v=%b, required all 0",
                 i, loads, stores, rsps, pending, latency_sum, snap_valid);
      end
    end
  endtask

  task automatic test_single_read();
    do_reset();
    req_valid = 4'b0001; req_ready = 4'b0001; tick(); idle();
    n_vec++;
    if (loads !== 0) begin n_err++; $display("FAIL single_loads_early got %0d want 0", loads); end
    tick();
    n_vec++;
    if (loads !== 1 || pending !== 1) begin
      n_err++; $display("FAIL single_visible got loads=%0d pend=%0d want 1/1", loads, pending);
    end
    repeat (4) tick();
    rsp_valid = 4'b0001; rsp_ready = 4'b0001; tick(); idle();
    n_vec++;
    if (latency_sum !== 5 || rsps !== 1 || max_pending !== 1 || pending !== 0) begin
      n_err++;
      $display("FAIL single_done got lat=%0d rsps=%0d maxp=%0d pend=%0d want 5/1/1/0",
               latency_sum, rsps, max_pending, pending);
    end
  endtask

  task automatic test_four_reads();
    do_reset();
    req_valid = 4'hf; req_ready = 4'hf; tick(); idle(); tick();
    n_vec++;
    if (pending !== 4) begin n_err++; $display("FAIL four_pend got %0d want 4", pending); end
    repeat (2) tick();
    rsp_valid = 4'hf; rsp_ready = 4'hf; tick(); idle();
    n_vec++;
    if (latency_sum !== 12 || max_pending !== 4 || stores !== 0 || loads !== 4 ||
        rsps !== 4 || pending !== 0) begin
      n_err++;
      $display("FAIL four_done got lat=%0d maxp=%0d st=%0d ld=%0d rsps=%0d pend=%0d want 12/4/0/4/4/0",
               latency_sum, max_pending, stores, loads, rsps, pending);
    end
  endtask

  task automatic test_underflow();
    do_reset();
    rsp_valid = 4'b0010; rsp_ready = 4'b0010; tick(); idle();
    n_vec++;
    if (pending !== 0 || err_underflow !== 1) begin
      n_err++; $display("FAIL underflow got pend=%0d uf=%b want 0/1", pending, err_underflow);
    end
    clear = 1; tick(); idle();
    n_vec++;
    if (err_underflow !== 0) begin
      n_err++; $display("FAIL underflow_clear got uf=%b want 0", err_underflow);
    end
  endtask

  task automatic test_clear_same_cycle();
    do_reset();
    req_valid = 4'b0101; req_ready = 4'hf; req_rw = 4'b0100; tick(); idle();
    tick(); tick();
    rsp_valid = 4'b0001; rsp_ready = 4'b0001; tick(); idle();
    n_vec++;
    if (loads !== 1 || stores !== 1 || pending !== 0) begin
      n_err++; $display("FAIL pre_clear got ld=%0d st=%0d pend=%0d want 1/1/0", loads, stores, pending);
    end
    req_valid = 4'hf; req_ready = 4'hf; req_rw = 4'b1100; clear = 1; tick(); idle();
    tick(); tick();
    n_vec++;
    if (loads !== 0 || stores !== 0 || pending !== 2 || max_pending !== 2) begin
      n_err++;
      $display("FAIL clear_same_cycle got ld=%0d st=%0d pend=%0d maxp=%0d want 0/0/2/2",
               loads, stores, pending, max_pending);
    end
  endtask

  task automatic test_snapshot();
    busy = 1;
    do_reset();
    req_valid = 4'hf; req_ready = 4'hf; tick();
    req_valid = 4'b0111; tick(); idle();
    repeat (3) tick();
    rsp_valid = 4'b0011; rsp_ready = 4'b0011; tick(); idle();
    n_vec++;
    if (snap_valid !== 0) begin n_err++; $display("FAIL snap_early got %b want 0", snap_valid); end
    busy = 0; tick();
    n_vec++;
    if (snap_valid !== 1 || snap_loads !== 7 || snap_latency !== 30) begin
      n_err++; $display("FAIL snap_take got v=%b ld=%0d lat=%0d want 1/7/30",
                        snap_valid, snap_loads, snap_latency);
    end
    req_valid = 4'hf; req_ready = 4'hf; tick(); idle(); tick(); tick();
    n_vec++;
    if (snap_valid !== 0 || snap_loads !== 7 || snap_latency !== 30 || loads !== 11) begin
      n_err++; $display("FAIL snap_hold got v=%b sld=%0d slat=%0d ld=%0d want 0/7/30/11",
                        snap_valid, snap_loads, snap_latency, loads);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    req_valid = 4'hf; req_ready = 4'hf;
    repeat (16384) tick();
    idle(); tick(); tick();
    n_vec++;
    if (pending !== 16'hffff || err_overflow !== 1 || loads !== 65536 ||
        max_pending !== 16'hffff || err_underflow !== 0) begin
      n_err++;
      $display("FAIL overflow got pend=%0d of=%b ld=%0d maxp=%0d uf=%b want 65535/1/65536/65535/0",
               pending, err_overflow, loads, max_pending, err_underflow);
    end
  endtask

  task automatic test_random();
    logic [298:0] exp_v, act_v;
    busy = 1;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      req_valid = 4'($urandom); req_ready = 4'($urandom | $urandom); req_rw = 4'($urandom);
      rsp_valid = 4'($urandom & $urandom); rsp_ready = 4'($urandom | $urandom);
      clear = ($urandom_range(0, 23) == 0);
      if ($urandom_range(0, 9) == 0) busy = ~busy;
      reset = ($urandom_range(0, 199) == 0);
      tick();
      exp_v = {CB'(m_loads), CB'(m_stores), CB'(m_rsps), PB'(m_pend), PB'(m_maxp),
               CB'(m_lat), m_uf, m_of, m_snap_v, CB'(m_snap_loads), CB'(m_snap_lat)};
      act_v = {loads, stores, rsps, pending, max_pending, latency_sum, err_underflow,
               err_overflow, snap_valid, snap_loads, snap_latency};
      n_vec++;
      if (act_v !== exp_v) begin
        n_err++;
        $display("FAIL random cyc %0d got %h want %h", i, act_v, exp_v);
      end
    end
    reset = 0; idle();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_four_reads();
    test_underflow();
    test_clear_same_cycle();
    test_snapshot();
    test_overflow();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
